// File: rtl/coh_probe_responder.sv
// Coherence probe responder: tracks locally cached lines and answers directory
// invalidation probes, writing a dirty line back before acknowledging it.
module coh_probe_responder #(
    parameter int unsigned LINE_ADDR_W = 32,
    parameter int unsigned N_ENTRIES   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inval_valid,
    input  logic [LINE_ADDR_W-1:0] inval_addr,
    output logic                   inval_ready,
    input  logic                   track_valid,
    input  logic [LINE_ADDR_W-1:0] track_addr,
    input  logic                   track_dirty,
    output logic                   track_ready,
    output logic                   wb_valid,
    output logic [LINE_ADDR_W-1:0] wb_addr,
    input  logic                   wb_ready,
    output logic                   ack_valid,
    output logic [LINE_ADDR_W-1:0] ack_addr,
    output logic [1:0]             ack_type,
    output logic                   ack_dirty,
    input  logic                   ack_ready,
    output logic                   busy
);

    localparam int unsigned IdxW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    typedef enum logic [1:0] {StIdle, StLookup, StWb, StAck} state_e;

    state_e                 state_q;
    logic [LINE_ADDR_W-1:0] probe_addr_q;
    logic [IdxW-1:0]        hit_idx_q;
    logic                   wb_valid_q, ack_valid_q, ack_dirty_q;
    logic [LINE_ADDR_W-1:0] wb_addr_q, ack_addr_q;

    logic [N_ENTRIES-1:0]   valid_q, valid_d, dirty_q, dirty_d;
    logic [LINE_ADDR_W-1:0] addr_q [N_ENTRIES];
    logic [LINE_ADDR_W-1:0] addr_d [N_ENTRIES];

    logic            t_hit, p_hit, p_dirty, alloc_found, full, track_fire, clr_en;
    logic [IdxW-1:0] t_idx, p_idx, alloc_idx, clr_idx;

    always_comb begin
        t_hit       = 1'b0;
        t_idx       = '0;
        p_hit       = 1'b0;
        p_idx       = '0;
        p_dirty     = 1'b0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < int'(N_ENTRIES); i++) begin
            if (valid_q[i] && addr_q[i] == track_addr) begin
                t_hit = 1'b1;
                t_idx = IdxW'(i);
            end
            if (valid_q[i] && addr_q[i] == probe_addr_q) begin
                p_hit   = 1'b1;
                p_idx   = IdxW'(i);
                p_dirty = dirty_q[i];
            end
            if (!valid_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IdxW'(i);
            end
        end
    end

    assign full = &valid_q;

    // A line under invalidation must not be re-filled until the probe completes.
    assign track_ready = (t_hit || !full) && !(state_q != StIdle && track_addr == probe_addr_q);
    assign track_fire  = track_valid && track_ready;

    always_comb begin
        clr_en  = 1'b0;
        clr_idx = '0;
        if (state_q == StLookup && p_hit && !p_dirty) begin
            clr_en  = 1'b1;
            clr_idx = p_idx;
        end else if (state_q == StWb && wb_ready) begin
            clr_en  = 1'b1;
            clr_idx = hit_idx_q;
        end
    end

    // The cleared entry is still valid this cycle, so allocation never picks it.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        addr_d  = addr_q;
        if (clr_en) valid_d[clr_idx] = 1'b0;
        if (track_fire) begin
            if (t_hit) begin
                dirty_d[t_idx] = dirty_q[t_idx] | track_dirty;
            end else begin
                valid_d[alloc_idx] = 1'b1;
                addr_d[alloc_idx]  = track_addr;
                dirty_d[alloc_idx] = track_dirty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        dirty_q <= dirty_d;
        addr_q  <= addr_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            probe_addr_q <= '0;
            hit_idx_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            ack_valid_q  <= 1'b0;
            ack_addr_q   <= '0;
            ack_dirty_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (inval_valid) begin
                        probe_addr_q <= inval_addr;
                        state_q      <= StLookup;
                    end
                end
                StLookup: begin
                    if (p_hit && p_dirty) begin
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= probe_addr_q;
                        hit_idx_q  <= p_idx;
                        state_q    <= StWb;
                    end else begin
                        ack_valid_q <= 1'b1;
                        ack_addr_q  <= probe_addr_q;
                        ack_dirty_q <= 1'b0;
                        state_q     <= StAck;
                    end
                end
                StWb: begin
                    if (wb_ready) begin
                        wb_valid_q  <= 1'b0;
                        ack_valid_q <= 1'b1;
                        ack_addr_q  <= probe_addr_q;
                        ack_dirty_q <= 1'b1;
                        state_q     <= StAck;
                    end
                end
                StAck: begin
                    if (ack_ready) begin
                        ack_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign inval_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign ack_valid   = ack_valid_q;
    assign ack_addr    = ack_addr_q;
    assign ack_dirty   = ack_dirty_q;
    assign ack_type    = 2'd2;

endmodule

// File: tb/tb_coh_probe_responder.sv
// Bench for coh_probe_responder: directed table, corner sequences and random
// traffic checked against a map-based model of the presence table.
module tb_coh_probe_responder;

    localparam int NE = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inval_valid, inval_ready, track_valid, track_dirty, track_ready;
    logic [31:0] inval_addr, track_addr, wb_addr, ack_addr;
    logic        wb_valid, wb_ready, ack_valid, ack_dirty, ack_ready, busy;
    logic [1:0]  ack_type;

    coh_probe_responder #(.LINE_ADDR_W(32), .N_ENTRIES(NE)) dut (
        .clk(clk), .rst_n(rst_n),
        .inval_valid(inval_valid), .inval_addr(inval_addr), .inval_ready(inval_ready),
        .track_valid(track_valid), .track_addr(track_addr), .track_dirty(track_dirty),
        .track_ready(track_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
        .ack_valid(ack_valid), .ack_addr(ack_addr), .ack_type(ack_type),
        .ack_dirty(ack_dirty), .ack_ready(ack_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mdl [logic [31:0]];  // line address -> dirty

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_ready(input logic [31:0] a);
        return mdl.exists(a) || mdl.num() < NE;
    endfunction

    function automatic bit m_dirty(input logic [31:0] a);
        if (!mdl.exists(a)) return 1'b0;
        return mdl[a];
    endfunction

    task automatic idle_inputs();
        inval_valid = 0; inval_addr = 0; track_valid = 0; track_addr = 0;
        track_dirty = 0; wb_ready = 0; ack_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
        mdl.delete();
    endtask

    task automatic do_track(input logic [31:0] a, input bit d, input bit exp);
        track_valid = 1; track_addr = a; track_dirty = d;
        #1;
        chk("track_ready", {31'd0, track_ready}, {31'd0, exp});
        tick();
        track_valid = 0;
        if (exp) mdl[a] = mdl.exists(a) ? (mdl[a] | d) : d;
    endtask

    // Full probe with expected writeback, wb/ack backpressure, optional blocked refill.
    task automatic do_probe(input logic [31:0] a, input bit exp_d, input int wbw,
                            input int ackw, input bit blk);
        chk("inval_ready_idle", {31'd0, inval_ready}, 32'd1);
        inval_valid = 1; inval_addr = a;
        tick();
        inval_valid = 0; inval_addr = 32'hdead_beef;
        if (blk) begin track_valid = 1; track_addr = a; track_dirty = 1; end
        #1;
        chk("lookup_busy", {31'd0, busy}, 32'd1);
        chk("lookup_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("lookup_ack_valid", {31'd0, ack_valid}, 32'd0);
        if (blk) chk("blk_track_ready", {31'd0, track_ready}, 32'd0);
        tick();
        if (exp_d) begin
            for (int k = 0; k <= wbw; k++) begin
                wb_ready = (k == wbw);
                #1;
                chk("wb_valid", {31'd0, wb_valid}, 32'd1);
                chk("wb_addr", wb_addr, a);
                chk("wb_ack_valid", {31'd0, ack_valid}, 32'd0);
                if (blk) chk("blk_track_ready", {31'd0, track_ready}, 32'd0);
                tick();
            end
            wb_ready = 0;
        end
        for (int k = 0; k <= ackw; k++) begin
            ack_ready = (k == ackw);
            #1;
            chk("ack_valid", {31'd0, ack_valid}, 32'd1);
            chk("ack_addr", ack_addr, a);
            chk("ack_dirty", {31'd0, ack_dirty}, {31'd0, exp_d});
            chk("ack_type", {30'd0, ack_type}, 32'd2);
            chk("ack_wb_valid", {31'd0, wb_valid}, 32'd0);
            chk("ack_inval_ready", {31'd0, inval_ready}, 32'd0);
            if (blk) chk("blk_track_ready", {31'd0, track_ready}, 32'd0);
            tick();
        end
        ack_ready = 0;
        track_valid = 0;
        #1;
        chk("post_ack_valid", {31'd0, ack_valid}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
        if (mdl.exists(a)) mdl.delete(a);
    endtask

    typedef struct {
        bit          is_probe;
        logic [31:0] addr;
        bit          dirty;
        int          wbw;
        int          ackw;
        bit          blk;
        bit          exp;  // track: expected track_ready; probe: expected writeback
    } vec_t;

    vec_t vecs [24];

    initial begin
        vecs[0]  = '{0, 32'h100, 0, 0, 0, 0, 1};
        vecs[1]  = '{1, 32'h100, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 32'h100, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 32'h200, 1, 0, 0, 0, 1};
        vecs[4]  = '{1, 32'h200, 0, 3, 0, 1, 1};
        vecs[5]  = '{1, 32'h200, 0, 0, 0, 0, 0};
        vecs[6]  = '{1, 32'h300, 0, 0, 5, 1, 0};
        vecs[7]  = '{0, 32'h500, 0, 0, 0, 0, 1};
        vecs[8]  = '{0, 32'h500, 1, 0, 0, 0, 1};
        vecs[9]  = '{0, 32'h500, 0, 0, 0, 0, 1};
        vecs[10] = '{1, 32'h500, 0, 1, 2, 0, 1};
        for (int i = 0; i < 8; i++) vecs[11+i] = '{0, 32'h1000 + 32'(i) * 32'h40, 0, 0, 0, 0, 1};
        vecs[19] = '{0, 32'h9000, 1, 0, 0, 0, 0};
        vecs[20] = '{0, 32'h1040, 1, 0, 0, 0, 1};
        vecs[21] = '{1, 32'h1000, 0, 0, 0, 0, 0};
        vecs[22] = '{0, 32'h9000, 1, 0, 0, 0, 1};
        vecs[23] = '{1, 32'h9000, 0, 0, 0, 0, 1};

        do_reset();
        #1;
        chk("rst_inval_ready", {31'd0, inval_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_ack_valid", {31'd0, ack_valid}, 32'd0);
        chk("rst_ack_dirty", {31'd0, ack_dirty}, 32'd0);
        chk("rst_wb_addr", wb_addr, 32'd0);
        chk("rst_ack_addr", ack_addr, 32'd0);
        chk("rst_ack_type", {30'd0, ack_type}, 32'd2);
        chk("rst_track_ready", {31'd0, track_ready}, 32'd1);

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].is_probe)
                do_probe(vecs[i].addr, vecs[i].exp, vecs[i].wbw, vecs[i].ackw, vecs[i].blk);
            else
                do_track(vecs[i].addr, vecs[i].dirty, vecs[i].exp);
        end
        // 0x1040 was rewritten dirty; its probe proves the hit path kept the slot.
        do_probe(32'h1040, 1, 0, 0, 0);

        // Same-cycle track and probe of one address: LOOKUP sees the dirty fill.
        do_reset();
        track_valid = 1; track_addr = 32'h700; track_dirty = 1;
        inval_valid = 1; inval_addr = 32'h700;
        #1;
        chk("same_track_ready", {31'd0, track_ready}, 32'd1);
        chk("same_inval_ready", {31'd0, inval_ready}, 32'd1);
        tick();
        track_valid = 0; inval_valid = 0;
        tick();
        chk("same_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("same_wb_addr", wb_addr, 32'h700);
        wb_ready = 1;
        tick();
        wb_ready = 0;
        chk("same_ack_dirty", {31'd0, ack_dirty}, 32'd1);
        ack_ready = 1;
        tick();
        ack_ready = 0;

        // Allocation during a LOOKUP clear must avoid the slot being cleared.
        do_reset();
        for (int i = 0; i < 7; i++) do_track(32'h2000 + 32'(i) * 32'h40, 0, 1);
        inval_valid = 1; inval_addr = 32'h2000;
        tick();
        inval_valid = 0;
        track_valid = 1; track_addr = 32'h3000; track_dirty = 1;
        #1;
        chk("lookup_alloc_ready", {31'd0, track_ready}, 32'd1);
        tick();
        track_valid = 0;
        chk("lookup_alloc_ack", {31'd0, ack_valid}, 32'd1);
        chk("lookup_alloc_ack_dirty", {31'd0, ack_dirty}, 32'd0);
        ack_ready = 1;
        tick();
        ack_ready = 0;
        mdl.delete(32'h2000);
        mdl[32'h3000] = 1;
        do_track(32'h3100, 0, 1);
        do_track(32'h3200, 0, 0);
        do_probe(32'h3000, 1, 0, 0, 0);

        // Refill of the line under writeback stalls; another line goes through.
        do_reset();
        do_track(32'h400, 1, 1);
        inval_valid = 1; inval_addr = 32'h400;
        tick();
        inval_valid = 0;
        tick();
        chk("wb400_valid", {31'd0, wb_valid}, 32'd1);
        track_valid = 1; track_addr = 32'h404; track_dirty = 1;
        #1;
        chk("wb404_track_ready", {31'd0, track_ready}, 32'd1);
        tick();
        mdl[32'h404] = 1;
        track_addr = 32'h400; track_dirty = 0;
        for (int k = 0; k < 3; k++) begin
            wb_ready = (k == 2);
            #1;
            chk("wb400_track_ready", {31'd0, track_ready}, 32'd0);
            tick();
        end
        wb_ready = 0;
        ack_ready = 1;
        #1;
        chk("ack400_track_ready", {31'd0, track_ready}, 32'd0);
        chk("ack400_dirty", {31'd0, ack_dirty}, 32'd1);
        tick();
        ack_ready = 0;
        #1;
        chk("idle400_track_ready", {31'd0, track_ready}, 32'd1);
        tick();
        track_valid = 0;
        mdl.delete(32'h400);
        mdl[32'h400] = 0;
        do_probe(32'h404, 1, 0, 0, 0);
        do_probe(32'h400, 0, 0, 0, 0);

        // Reset in WB aborts with no ack and leaves the table empty.
        do_track(32'h800, 1, 1);
        inval_valid = 1; inval_addr = 32'h800;
        tick();
        inval_valid = 0;
        tick();
        chk("abort_wb_valid_pre", {31'd0, wb_valid}, 32'd1);
        rst_n = 0;
        tick();
        rst_n = 1;
        mdl.delete();
        chk("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("abort_ack_valid", {31'd0, ack_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_wb_addr", wb_addr, 32'd0);
        do_probe(32'h800, 0, 0, 0, 0);

        // Random traffic over a small address pool so hits and full-table stalls occur.
        do_reset();
        for (int it = 0; it < 400; it++) begin
            logic [31:0] a;
            a = 32'h4000 + 32'($urandom_range(0, 15)) * 32'h40;
            if ($urandom_range(0, 9) < 6)
                do_track(a, 1'($urandom_range(0, 1)), m_ready(a));
            else
                do_probe(a, m_dirty(a), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coh_probe_responder.md
COH_PROBE_RESPONDER -- requirements
Module: coh_probe_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning): LINE_ADDR_W, 32, line address width.
REQ-002 SHALL have parameter N_ENTRIES, 8, tracked-line slots in the local presence table.
REQ-003 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, clock.
- rst_n, in, 1, reset, synchronous, active-low.
- inval_valid, in, 1, invalidation probe from the coherence directory.
- inval_addr, in, LINE_ADDR_W, probed line address.
- inval_ready, out, 1, probe accepted.
- track_valid, in, 1, local cache reports a line fill or write.
- track_addr, in, LINE_ADDR_W, line address of the fill or write.
- track_dirty, in, 1, 1 = write, which marks the line dirty.
- track_ready, out, 1, track update accepted.
- wb_valid, out, 1, dirty-line writeback request.
- wb_addr, out, LINE_ADDR_W, writeback line address.
- wb_ready, in, 1, writeback accepted.
- ack_valid, out, 1, probe acknowledge to the directory.
- ack_addr, out, LINE_ADDR_W, acknowledged line address.
- ack_type, out, 2, constant 2'd2 (ProbeAck encoding).
- ack_dirty, out, 1, 1 = the line was written back before this ack.
- ack_ready, in, 1, directory consumed the ack.
- busy, out, 1, FSM not in IDLE.

Function
REQ-004 SHALL hold a table of N_ENTRIES entries, each {valid, addr, dirty}; a given addr SHALL occupy at most one valid entry.
REQ-005 SHALL implement the FSM states IDLE, LOOKUP, WB and ACK; inval_ready SHALL equal (state==IDLE).
REQ-006 IDLE: on inval_valid&&inval_ready, latch inval_addr into probe_addr and go to LOOKUP next cycle.
REQ-007 LOOKUP lasts exactly one cycle and compares probe_addr against all valid entries:
- hit with dirty=1 -> go to WB.
- hit with dirty=0 -> clear the entry's valid bit, set ack_dirty=0, go to ACK.
- miss -> set ack_dirty=0, go to ACK.
REQ-008 WB: wb_valid=1 and wb_addr=probe_addr, held stable until wb_ready is sampled high. On that handshake: clear the entry, set ack_dirty=1, go to ACK.
REQ-009 ACK: ack_valid=1, with ack_addr=probe_addr, ack_dirty and ack_type stable until ack_ready. On that handshake go to IDLE.
REQ-010 Probe latency with no backpressure SHALL be:
- clean or miss: ack_valid asserted 2 cycles after probe acceptance.
- dirty: wb_valid asserted 2 cycles after acceptance; ack_valid asserted the cycle after the wb handshake.
REQ-011 Track update on track_valid&&track_ready:
- addr hits a valid entry -> entry dirty |= track_dirty.
- miss -> allocate the lowest-index invalid entry with {1, track_addr, track_dirty}.
REQ-012 track_ready SHALL be 0 when track_addr misses and all entries are valid (table full); the producer stalls.
REQ-013 track_ready SHALL be 0 when state != IDLE and track_addr == probe_addr. This blocks re-fill of a line under invalidation.
REQ-014 Same-cycle events in IDLE:
- A track update and a probe to the same address are both accepted; the track update is applied first, so LOOKUP sees it.
- A track update to a different address proceeds in every state.
REQ-015 A track update in the same cycle as a LOOKUP or WB clear of a different entry SHALL be applied; allocation SHALL NOT select the entry being cleared that cycle.
REQ-016 ack_type SHALL be the constant 2'd2 at all times.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 While rst_n=0 at a clk edge:
- state=IDLE and all entry valid bits = 0.
- wb_valid=0, ack_valid=0, ack_dirty=0.
- probe_addr, wb_addr and ack_addr = 0.
REQ-019 After reset: inval_ready=1 and busy=0; track_ready=1 unless REQ-012 applies.
REQ-020 Reset asserted in LOOKUP, WB or ACK SHALL abort the operation with no ack and no writeback emitted. The directory re-issues the probe.

Verification
REQ-021 Track 0x100 clean; probe 0x100; ack_ready=1 -> ack_valid 2 cycles after accept, ack_addr=0x100, ack_dirty=0, ack_type=2; entry invalid afterwards.
REQ-022 Track 0x200 with dirty=1; probe 0x200; hold wb_ready=0 for 3 cycles -> wb_valid with wb_addr=0x200 held 4 cycles; ack (dirty=1) asserted the cycle after wb_ready=1.
REQ-023 Probe 0x300, never tracked -> ack_dirty=0, wb_valid never asserted; ack_valid held while ack_ready=0 for 5 cycles, inval_ready=0 throughout.
REQ-024 Fill 8 distinct lines -> track_ready=0 for a 9th new address and 1 for a re-write of an existing line; probe one line -> after its clear, the 9th address allocates into the freed slot.
REQ-025 During a WB of 0x400, present track 0x400 -> track_ready=0 until the FSM returns to IDLE; a concurrent track of 0x404 is accepted.
REQ-026 Assert rst_n=0 while in WB -> next cycle wb_valid=0, ack_valid=0, busy=0, table empty.
